dotprod_operand_loader: RTL

- Upstream feeder for the dot-product compute core.
- Accepts (a,b) element pairs over a valid/ready stream and writes them into two DEPTH-entry operand banks.
- Hands the core the element count n with a start pulse, serves the core's synchronous bank reads, then captures the core's result and offers it downstream on a valid/ready result port.
- Replaces file-preloaded operand memories with a runtime-loaded path.

---
 rtl/dotprod_operand_loader.sv | 117 +++++++++++
 1 files changed

// File: rtl/dotprod_operand_loader.sv
// Operand loader for the dot-product core: streams (a,b) pairs into
// two banks, launches the core, and forwards its result downstream.
module dotprod_operand_loader #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_a,
  input  logic [DATA_W-1:0] s_b,
  input  logic              s_last,
  output logic              core_start,
  output logic [DATA_W-1:0] core_n,
  input  logic [ADDR_W-1:0] core_addr,
  output logic [DATA_W-1:0] core_a,
  output logic [DATA_W-1:0] core_b,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_ready,
  output logic              trunc_err
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_START,
    S_WAIT,
    S_RESULT
  } state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W:0]     r_wr_ptr;
  logic [ADDR_W:0]     w_cnt;
  logic [DATA_W-1:0]   r_core_n;
  logic [DATA_W-1:0]   r_core_a;
  logic [DATA_W-1:0]   r_core_b;
  logic                r_res_valid;
  logic [DATA_W-1:0]   r_res_data;
  logic                r_trunc;
  logic                w_accept;
  logic                w_at_end;
  logic                w_close;

  logic [DATA_W-1:0]   r_bank_a [DEPTH];
  logic [DATA_W-1:0]   r_bank_b [DEPTH];

  assign s_ready    = (r_state == S_LOAD);
  assign core_start = (r_state == S_START);
  assign w_accept   = s_valid & s_ready;
  assign w_at_end   = (r_wr_ptr == LAST_IDX);
  assign w_cnt      = r_wr_ptr + 1'b1;
  // A vector closes on s_last or when the banks are full.
  assign w_close    = w_accept & (s_last | w_at_end);

  assign core_n    = r_core_n;
  assign core_a    = r_core_a;
  assign core_b    = r_core_b;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign trunc_err = r_trunc;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_LOAD:   if (w_close) w_state_nxt = S_START;
      S_START:  w_state_nxt = S_WAIT;
      S_WAIT:   if (core_done) w_state_nxt = S_RESULT;
      S_RESULT: if (res_ready) w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= S_LOAD;
      r_wr_ptr    <= '0;
      r_core_n    <= '0;
      r_core_a    <= '0;
      r_core_b    <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_trunc     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_core_a <= r_bank_a[core_addr];
      r_core_b <= r_bank_b[core_addr];
      if (w_accept) r_wr_ptr <= w_cnt;
      if (w_close) begin
        r_core_n <= DATA_W'(w_cnt);
        if (!s_last) r_trunc <= 1'b1;
      end
      if (r_state == S_WAIT && core_done) begin
        r_res_data  <= core_result;
        r_res_valid <= 1'b1;
      end
      if (r_state == S_RESULT && res_ready) begin
        r_res_valid <= 1'b0;
        r_wr_ptr    <= '0;
      end
    end
  end

  // Banks are plain RAM: no reset, contents survive across vectors.
  always_ff @(posedge sys_clk) begin
    if (w_accept) begin
      r_bank_a[r_wr_ptr[ADDR_W-1:0]] <= s_a;
      r_bank_b[r_wr_ptr[ADDR_W-1:0]] <= s_b;
    end
  end

endmodule
